// File: rtl/cfg_loader.sv
`timescale 1ns/1ps
// cfg_loader
// Receives a serial configuration bitstream, hunts for the sync byte,
// checks the block count, shifts the payload into a shadow register and
// commits it to the flat cfg bus only when the received CRC-8 matches.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   bit_in     serial bitstream data
//   bit_valid  bit_in is valid this cycle
//   bit_ready  loader accepts a bit this cycle (low only in CHECK)
//   cfg_out    committed config, block k at [k*CFG_SIZE +: CFG_SIZE]
//   cfg_valid  high once any frame has been committed since reset
//   busy       high while a frame is in progress (COUNT..CHECK)
//   done       one-cycle pulse on a successful commit
//   err        one-cycle pulse on a rejected frame
//   err_code   01 = count mismatch, 10 = CRC mismatch; held until next err/rst
module cfg_loader #(
    parameter int         NUM_BLOCKS = 2,
    parameter int         CFG_SIZE   = 18,
    parameter logic [7:0] SYNC       = 8'hA5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           bit_in,
    input  logic                           bit_valid,
    output logic                           bit_ready,
    output logic [NUM_BLOCKS*CFG_SIZE-1:0] cfg_out,
    output logic                           cfg_valid,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [1:0]                     err_code
);

    localparam int TOTAL = NUM_BLOCKS * CFG_SIZE;
    localparam int PW    = $clog2(TOTAL + 1);

    typedef enum logic [2:0] {
        HUNT,
        COUNT,
        PAYLOAD,
        CRC,
        CHECK
    } state_t;

    state_t            state;
    logic [7:0]        window;
    logic [7:0]        field_sr;
    logic [7:0]        crc;
    logic [2:0]        field_cnt;
    logic [PW-1:0]     pay_cnt;
    logic [TOTAL-1:0]  shadow;
    logic [TOTAL-1:0]  shadow_blocks;

    logic              accept;
    logic [7:0]        window_next;
    logic [7:0]        field_next;
    logic [7:0]        crc_next;

    assign bit_ready   = (state != CHECK);
    assign busy        = (state != HUNT);
    assign accept      = bit_valid && bit_ready;
    assign window_next = {window[6:0], bit_in};
    assign field_next  = {field_sr[6:0], bit_in};
    // Serial CRC-8, poly 0x07, MSB-first feedback.
    assign crc_next    = {crc[6:0], 1'b0} ^ ((crc[7] ^ bit_in) ? 8'h07 : 8'h00);

    // The shadow fills from its top bit down, so the first block on the wire
    // lands in the highest slice. Block 0 is sent first but belongs at the
    // bottom of cfg_out, so the slices are reversed on the way to the bus.
    always_comb begin
        shadow_blocks = '0;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            shadow_blocks[k*CFG_SIZE +: CFG_SIZE] =
                shadow[(NUM_BLOCKS-1-k)*CFG_SIZE +: CFG_SIZE];
        end
    end

    // Frame state machine. done/err are pulses, so they default low each
    // cycle; counters are cleared on every state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            window    <= '0;
            field_sr  <= '0;
            crc       <= '0;
            field_cnt <= '0;
            pay_cnt   <= '0;
            shadow    <= '0;
            cfg_out   <= '0;
            cfg_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                HUNT: begin
                    if (accept) begin
                        window <= window_next;
                        if (window_next == SYNC) begin
                            state     <= COUNT;
                            field_cnt <= '0;
                        end
                    end
                end
                COUNT: begin
                    if (accept) begin
                        field_sr  <= field_next;
                        field_cnt <= field_cnt + 3'd1;
                        if (field_cnt == 3'd7) begin
                            field_cnt <= '0;
                            if (field_next == 8'(NUM_BLOCKS)) begin
                                state   <= PAYLOAD;
                                crc     <= '0;
                                pay_cnt <= '0;
                            end else begin
                                state    <= HUNT;
                                window   <= '0;
                                err      <= 1'b1;
                                err_code <= 2'b01;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        shadow  <= (shadow << 1) | TOTAL'(bit_in);
                        crc     <= crc_next;
                        pay_cnt <= pay_cnt + 1'b1;
                        if (pay_cnt == PW'(TOTAL - 1)) begin
                            state     <= CRC;
                            field_cnt <= '0;
                            pay_cnt   <= '0;
                        end
                    end
                end
                CRC: begin
                    if (accept) begin
                        field_sr  <= field_next;
                        field_cnt <= field_cnt + 3'd1;
                        if (field_cnt == 3'd7) begin
                            state     <= CHECK;
                            field_cnt <= '0;
                        end
                    end
                end
                CHECK: begin
                    // field_sr holds the received CRC byte here.
                    if (field_sr == crc) begin
                        cfg_out   <= shadow_blocks;
                        cfg_valid <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        err      <= 1'b1;
                        err_code <= 2'b10;
                    end
                    state     <= HUNT;
                    window    <= '0;
                    field_cnt <= '0;
                    pay_cnt   <= '0;
                end
                default: begin
                    state  <= HUNT;
                    window <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_loader.sv
`timescale 1ns/1ps
// tb_cfg_loader
// Drives framed bitstreams into cfg_loader. Each frame's expected outcome is
// derived from the frame rules and pushed into a queue; a monitor pops an
// entry whenever done or err pulses and compares the DUT against it.
module tb_cfg_loader;

    localparam int         NB    = 2;
    localparam int         CS    = 18;
    localparam int         TOTAL = NB * CS;
    localparam logic [7:0] SYNC  = 8'hA5;

    logic             clk = 1'b0;
    logic             rst;
    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic [TOTAL-1:0] cfg_out;
    logic             cfg_valid;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;

    cfg_loader #(
        .NUM_BLOCKS(NB),
        .CFG_SIZE  (CS),
        .SYNC      (SYNC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (bit_in),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready),
        .cfg_out  (cfg_out),
        .cfg_valid(cfg_valid),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    // Free-running edge counter used to time done/err pulses.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic             is_err;
        logic [1:0]       code;
        logic [TOTAL-1:0] cfg;
        logic             valid;
    } exp_t;

    exp_t exp_q[$];
    int   due_q[$];

    // Reference state: what the bus should hold after all frames so far.
    logic [TOTAL-1:0] model_cfg   = '0;
    logic             model_valid = 1'b0;
    logic [1:0]       model_code  = 2'b00;

    // CRC as the remainder of payload(x)*x^8 divided by x^8+x^2+x+1.
    function automatic logic [7:0] model_crc(input logic [TOTAL-1:0] tx);
        logic [TOTAL+7:0] m;
        m = {tx, 8'h00};
        for (int i = TOTAL + 7; i >= 8; i--) begin
            if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
        end
        return m[7:0];
    endfunction

    // Wire order (block 0 first) to bus layout (block k at k*CS).
    function automatic logic [TOTAL-1:0] to_cfg(input logic [TOTAL-1:0] tx);
        logic [TOTAL-1:0] c;
        c = '0;
        for (int k = 0; k < NB; k++) c[k*CS +: CS] = tx[TOTAL-1-k*CS -: CS];
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Present one bit at a negedge, optionally after random idle cycles,
    // hold it until bit_ready, and return at the negedge after the transfer.
    task automatic sendBit(input logic b, input int stall);
        int guard;
        guard = 0;
        while ($urandom_range(99) < stall && guard < 8) begin
            bit_valid = 1'b0;
            bit_in    = 1'($urandom);
            @(negedge clk);
            guard++;
        end
        bit_in    = b;
        bit_valid = 1'b1;
        guard     = 0;
        while (!bit_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) checkOutput("bit_ready_timeout", 64'(bit_ready), 64'd1);
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    // Send one frame; abort_at >= 0 pulses rst before that payload bit.
    task automatic applyStimulus(input logic [TOTAL-1:0] tx, input logic [7:0] cnt,
                                 input logic [7:0] crc_xor, input int stall, input int abort_at);
        exp_t       e;
        logic [7:0] crc;
        crc = model_crc(tx) ^ crc_xor;

        if (abort_at < 0) begin
            if (cnt != 8'(NB)) begin
                model_code = 2'b01;
                e.is_err   = 1'b1;
            end else if (crc_xor != 8'h00) begin
                model_code = 2'b10;
                e.is_err   = 1'b1;
            end else begin
                model_cfg   = to_cfg(tx);
                model_valid = 1'b1;
                e.is_err    = 1'b0;
            end
            e.code  = model_code;
            e.cfg   = model_cfg;
            e.valid = model_valid;
            exp_q.push_back(e);
        end

        for (int i = 7; i >= 0; i--) begin
            sendBit(SYNC[i], stall);
            if (i == 1) checkOutput("busy_before_sync_end", 64'(busy), 64'd0);
            if (i == 0) checkOutput("busy_after_sync", 64'(busy), 64'd1);
        end
        for (int i = 7; i >= 0; i--) sendBit(cnt[i], stall);
        if (cnt != 8'(NB)) begin
            due_q.push_back(cyc);
            checkOutput("busy_after_bad_count", 64'(busy), 64'd0);
            return;
        end
        for (int n = 0; n < TOTAL; n++) begin
            if (n == abort_at) begin
                bit_valid   = 1'b0;
                rst         = 1'b1;
                @(negedge clk);
                rst         = 1'b0;
                model_cfg   = '0;
                model_valid = 1'b0;
                model_code  = 2'b00;
                checkOutput("abort_cfg_out", 64'(cfg_out), 64'd0);
                checkOutput("abort_cfg_valid", 64'(cfg_valid), 64'd0);
                checkOutput("abort_busy", 64'(busy), 64'd0);
                checkOutput("abort_err_code", 64'(err_code), 64'd0);
                return;
            end
            sendBit(tx[TOTAL-1-n], stall);
        end
        for (int i = 7; i >= 0; i--) sendBit(crc[i], stall);
        due_q.push_back(cyc + 1);
        checkOutput("ready_low_in_check", 64'(bit_ready), 64'd0);
        checkOutput("busy_in_check", 64'(busy), 64'd1);
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: every done/err pulse must match the oldest entry.
    initial begin
        exp_t e;
        int   d;
        forever begin
            @(negedge clk);
            #1;
            if (done || err) begin
                if (exp_q.size() == 0 || due_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pulse: got done=%0b err=%0b, expected none", done, err);
                end else begin
                    e = exp_q.pop_front();
                    d = due_q.pop_front();
                    checkOutput("pulse_cycle", 64'(cyc), 64'(d));
                    checkOutput("err", 64'(err), 64'(e.is_err));
                    checkOutput("done", 64'(done), 64'(!e.is_err));
                    checkOutput("err_code", 64'(err_code), 64'(e.code));
                    checkOutput("cfg_out", 64'(cfg_out), 64'(e.cfg));
                    checkOutput("cfg_valid", 64'(cfg_valid), 64'(e.valid));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [TOTAL-1:0] tx;
        logic [TOTAL-1:0] s2;
        logic [7:0]       cnt;
        logic [7:0]       cx;
        int               kind;
        int               guard;

        s2        = {18'h2AAAA, 18'h15555};
        rst       = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_cfg_out", 64'(cfg_out), 64'd0);
        checkOutput("reset_cfg_valid", 64'(cfg_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_err", 64'(err), 64'd0);
        checkOutput("reset_err_code", 64'(err_code), 64'd0);
        checkOutput("reset_bit_ready", 64'(bit_ready), 64'd1);

        // Leading noise then the reference frame.
        sendBit(1'b1, 0);
        sendBit(1'b1, 0);
        applyStimulus(s2, 8'h02, 8'h00, 0, -1);
        idle(3);
        checkOutput("s2_block0", 64'(cfg_out[17:0]), 64'h2AAAA);
        checkOutput("s2_block1", 64'(cfg_out[35:18]), 64'h15555);
        checkOutput("s2_cfg_valid", 64'(cfg_valid), 64'd1);

        // Good frame followed by a frame with a wrong block count.
        applyStimulus(s2, 8'h02, 8'h00, 0, -1);
        idle(2);
        applyStimulus(s2, 8'h03, 8'h00, 0, -1);
        idle(3);

        // Corrupted CRC must leave the previous config in place.
        applyStimulus({18'h2AAAA, 18'h00001}, 8'h02, 8'h01, 0, -1);
        idle(3);
        checkOutput("crc_err_keeps_cfg", 64'(cfg_out), 64'(to_cfg(s2)));

        // Stalled frame aborted by reset, then a clean frame.
        for (int i = 0; i < TOTAL; i++) tx[i] = 1'($urandom);
        applyStimulus(tx, 8'h02, 8'h00, 50, TOTAL / 2);
        idle(3);
        for (int i = 0; i < TOTAL; i++) tx[i] = 1'($urandom);
        applyStimulus(tx, 8'h02, 8'h00, 0, -1);
        idle(3);

        // Two frames back to back.
        for (int i = 0; i < TOTAL; i++) tx[i] = 1'($urandom);
        applyStimulus(tx, 8'h02, 8'h00, 0, -1);
        for (int i = 0; i < TOTAL; i++) tx[i] = 1'($urandom);
        applyStimulus(tx, 8'h02, 8'h00, 0, -1);
        idle(3);
        checkOutput("b2b_final_cfg", 64'(cfg_out), 64'(to_cfg(tx)));

        // Randomized mix of good, bad-count and bad-CRC frames.
        for (int f = 0; f < 16; f++) begin
            for (int i = 0; i < TOTAL; i++) tx[i] = 1'($urandom);
            kind = int'($urandom_range(99));
            cnt  = 8'(NB);
            cx   = 8'h00;
            if (kind < 15) begin
                cnt = 8'($urandom_range(255));
                if (cnt == 8'(NB)) cnt = cnt + 8'd1;
            end else if (kind < 30) begin
                cx = 8'($urandom_range(255, 1));
            end
            applyStimulus(tx, cnt, cx, int'($urandom_range(1)) * 30, -1);
            idle(int'($urandom_range(3)));
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        checkOutput("final_cfg_out", 64'(cfg_out), 64'(model_cfg));
        checkOutput("final_cfg_valid", 64'(cfg_valid), 64'(model_valid));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
